reg_bank_arb: RTL and testbench

REG_BANK_ARB -- requirements
Module: reg_bank_arb

---
 rtl/reg_bank_arb.sv | 180 ++++++++++++++++++
 tb/tb_reg_bank_arb.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_arb.sv
// reg_bank_arb: two-requester write arbiter in front of a small register bank.
//
// A request seen in IDLE is granted on the next edge (one-cycle registered gnt
// pulse). The winner's addr/data are captured into holding registers, and the
// bank is written on the edge that ends the grant cycle. When both requesters
// are active, a round-robin pointer picks the winner. After each write the
// pointer moves to the requester that lost.
//
// Parameters:
//   WIDTH  data bits per bank entry
//   DEPTH  number of bank entries (addresses are taken modulo DEPTH)
//
// Ports:
//   Clk                  clock, rising edge
//   rst                  asynchronous, active-low reset
//   req0/addr0/data0     write request, target entry and data, requester 0
//   req1/addr1/data1     write request, target entry and data, requester 1
//   gnt0, gnt1           registered one-cycle grant pulses
//   busy                 high while a write is in progress (WRITE state)
//   raddr                read address
//   rdata                combinational read of the registered bank at raddr
//   wr_cnt               saturating count of completed writes
//                        (present only when ARB_STATS_EN is defined)
//
// Optional feature macro: ARB_STATS_EN

module reg_bank_arb #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             Clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [AW-1:0]    addr0,
    input  logic [WIDTH-1:0] data0,
    input  logic             req1,
    input  logic [AW-1:0]    addr1,
    input  logic [WIDTH-1:0] data1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    input  logic [AW-1:0]    raddr,
`ifdef ARB_STATS_EN
    output logic [7:0]       wr_cnt,
`endif
    output logic [WIDTH-1:0] rdata
);

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_e;

    // Fold an address into the bank range (identity when DEPTH is a power of two).
    function automatic logic [AW-1:0] fold_addr(input logic [AW-1:0] a);
        return AW'(32'(a) % DEPTH);
    endfunction

    state_e           state_q, state_d;
    logic             ptr_q, ptr_d;       // 0: requester 0 has priority
    logic             win_q, win_d;       // requester granted in this WRITE
    logic [AW-1:0]    haddr_q, haddr_d;
    logic [WIDTH-1:0] hdata_q, hdata_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic             busy_q, busy_d;
    logic             wr_en_c;
    logic             any_req_c;
    logic             pick1_c;

    logic [WIDTH-1:0] bank_q [DEPTH];

    // Requester 1 wins when it is alone, or when both ask and it holds priority.
    assign any_req_c = req0 | req1;
    assign pick1_c   = req1 & (~req0 | ptr_q);

    // State register plus registered outputs and holding registers.
    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            win_q   <= 1'b0;
            haddr_q <= '0;
            hdata_q <= '0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            haddr_q <= haddr_d;
            hdata_q <= hdata_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (any_req_c) state_d = WRITE;
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath control: grant and capture on IDLE->WRITE, commit on WRITE->IDLE.
    always_comb begin
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        busy_d  = 1'b0;
        ptr_d   = ptr_q;
        win_d   = win_q;
        haddr_d = haddr_q;
        hdata_d = hdata_q;
        wr_en_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_req_c) begin
                    busy_d  = 1'b1;
                    gnt0_d  = ~pick1_c;
                    gnt1_d  = pick1_c;
                    win_d   = pick1_c;
                    haddr_d = pick1_c ? fold_addr(addr1) : fold_addr(addr0);
                    hdata_d = pick1_c ? data1 : data0;
                end
            end
            WRITE: begin
                wr_en_c = 1'b1;
                ptr_d   = ~win_q;
            end
            default: begin
                wr_en_c = 1'b0;
            end
        endcase
    end

    // Register bank; an async reset during WRITE aborts the pending commit.
    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                bank_q[i] <= '0;
            end
        end else if (wr_en_c) begin
            bank_q[haddr_q] <= hdata_q;
        end
    end

`ifdef ARB_STATS_EN
    logic [7:0] wr_cnt_q, wr_cnt_d;

    // Completed-write counter, saturating at 255.
    always_comb begin
        wr_cnt_d = wr_cnt_q;
        if (wr_en_c && (wr_cnt_q != 8'hFF)) begin
            wr_cnt_d = wr_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            wr_cnt_q <= 8'd0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign wr_cnt = wr_cnt_q;
`endif

    assign gnt0  = gnt0_q;
    assign gnt1  = gnt1_q;
    assign busy  = busy_q;
    assign rdata = bank_q[fold_addr(raddr)];

endmodule

// File: tb/tb_reg_bank_arb.sv
// Directed testbench for reg_bank_arb (WIDTH=4, DEPTH=4).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.

module tb_reg_bank_arb;

    logic       Clk;
    logic       rst;
    logic       req0, req1;
    logic [1:0] addr0, addr1, raddr;
    logic [3:0] data0, data1, rdata;
    logic       gnt0, gnt1, busy;
`ifdef ARB_STATS_EN
    logic [7:0] wr_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    reg_bank_arb #(.WIDTH(4), .DEPTH(4)) dut (
        .Clk   (Clk),
        .rst   (rst),
        .req0  (req0),
        .addr0 (addr0),
        .data0 (data0),
        .req1  (req1),
        .addr1 (addr1),
        .data1 (data1),
        .gnt0  (gnt0),
        .gnt1  (gnt1),
        .busy  (busy),
        .raddr (raddr),
`ifdef ARB_STATS_EN
        .wr_cnt(wr_cnt),
`endif
        .rdata (rdata)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        addr0 = '0; addr1 = '0; data0 = '0; data1 = '0; raddr = '0;
        @(posedge Clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req0 = 1'b1; addr0 = 2'd1; data0 = 4'h5;
        req1 = 1'b0; addr1 = '0; data1 = '0; raddr = '0;
        repeat (2) @(posedge Clk);
        #1;
        n_tests++; if (gnt0 !== 1'b0) begin n_fail++; $display("FAIL reset_gnt0: got %b exp 0", gnt0); end
        n_tests++; if (gnt1 !== 1'b0) begin n_fail++; $display("FAIL reset_gnt1: got %b exp 0", gnt1); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", busy); end
        for (int i = 0; i < 4; i++) begin
            raddr = 2'(i);
            #1;
            n_tests++; if (rdata !== 4'h0) begin n_fail++; $display("FAIL reset_bank[%0d]: got %h exp 0", i, rdata); end
        end
        req0 = 1'b0;
        rst = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        req0 = 1'b1; addr0 = 2'd2; data0 = 4'hA; raddr = 2'd2;
        tick();
        n_tests++; if (gnt0 !== 1'b1) begin n_fail++; $display("FAIL single_gnt0: got %b exp 1", gnt0); end
        n_tests++; if (gnt1 !== 1'b0) begin n_fail++; $display("FAIL single_gnt1: got %b exp 0", gnt1); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b exp 1", busy); end
        n_tests++; if (rdata !== 4'h0) begin n_fail++; $display("FAIL single_old: got %h exp 0", rdata); end
        // addr/data changes after the grant must not affect the held write
        req0 = 1'b0; addr0 = 2'd1; data0 = 4'h3;
        tick();
        n_tests++; if (gnt0 !== 1'b0) begin n_fail++; $display("FAIL single_gnt0_fall: got %b exp 0", gnt0); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_fall: got %b exp 0", busy); end
        n_tests++; if (rdata !== 4'hA) begin n_fail++; $display("FAIL single_new: got %h exp a", rdata); end
        for (int i = 0; i < 4; i++) begin
            if (i != 2) begin
                raddr = 2'(i);
                #1;
                n_tests++; if (rdata !== 4'h0) begin n_fail++; $display("FAIL single_other[%0d]: got %h exp 0", i, rdata); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] e0;
        logic [7:0] e1;
        e0 = 8'b0001_0001;
        e1 = 8'b0100_0100;
        do_reset();
        req0 = 1'b1; addr0 = 2'd0; data0 = 4'h1;
        req1 = 1'b1; addr1 = 2'd1; data1 = 4'h2;
        for (int c = 0; c < 8; c++) begin
            tick();
            n_tests++; if (gnt0 !== e0[c]) begin n_fail++; $display("FAIL b2b_gnt0 cyc%0d: got %b exp %b", c, gnt0, e0[c]); end
            n_tests++; if (gnt1 !== e1[c]) begin n_fail++; $display("FAIL b2b_gnt1 cyc%0d: got %b exp %b", c, gnt1, e1[c]); end
        end
        req0 = 1'b0; req1 = 1'b0;
        raddr = 2'd0; #1;
        n_tests++; if (rdata !== 4'h1) begin n_fail++; $display("FAIL b2b_bank0: got %h exp 1", rdata); end
        raddr = 2'd1; #1;
        n_tests++; if (rdata !== 4'h2) begin n_fail++; $display("FAIL b2b_bank1: got %h exp 2", rdata); end
    endtask

    task automatic test_ptr();
        do_reset();
        req1 = 1'b1; addr1 = 2'd3; data1 = 4'h7;
        tick();
        n_tests++; if (gnt1 !== 1'b1) begin n_fail++; $display("FAIL ptr_gnt1_first: got %b exp 1", gnt1); end
        n_tests++; if (gnt0 !== 1'b0) begin n_fail++; $display("FAIL ptr_gnt0_first: got %b exp 0", gnt0); end
        req0 = 1'b1; addr0 = 2'd2; data0 = 4'h4;
        tick();
        n_tests++; if ((gnt0 | gnt1) !== 1'b0) begin n_fail++; $display("FAIL ptr_gap: got %b%b exp 00", gnt0, gnt1); end
        tick();
        n_tests++; if (gnt0 !== 1'b1) begin n_fail++; $display("FAIL ptr_gnt0_second: got %b exp 1", gnt0); end
        n_tests++; if (gnt1 !== 1'b0) begin n_fail++; $display("FAIL ptr_gnt1_second: got %b exp 0", gnt1); end
        req0 = 1'b0; req1 = 1'b0;
        tick();
        raddr = 2'd2; #1;
        n_tests++; if (rdata !== 4'h4) begin n_fail++; $display("FAIL ptr_bank2: got %h exp 4", rdata); end
        raddr = 2'd3; #1;
        n_tests++; if (rdata !== 4'h7) begin n_fail++; $display("FAIL ptr_bank3: got %h exp 7", rdata); end
    endtask

    task automatic test_reset_abort();
        do_reset();
        req0 = 1'b1; addr0 = 2'd3; data0 = 4'hF; raddr = 2'd3;
        tick();
        n_tests++; if (gnt0 !== 1'b1) begin n_fail++; $display("FAIL abort_gnt0_pre: got %b exp 1", gnt0); end
        req0 = 1'b0;
        rst = 1'b0;
        #1;
        n_tests++; if (gnt0 !== 1'b0) begin n_fail++; $display("FAIL abort_gnt0: got %b exp 0", gnt0); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b exp 0", busy); end
        n_tests++; if (rdata !== 4'h0) begin n_fail++; $display("FAIL abort_bank3: got %h exp 0", rdata); end
        #1;
        rst = 1'b1;
        req1 = 1'b1; addr1 = 2'd2; data1 = 4'h9;
        tick();
        n_tests++; if (gnt1 !== 1'b1) begin n_fail++; $display("FAIL abort_restart_gnt1: got %b exp 1", gnt1); end
        n_tests++; if (gnt0 !== 1'b0) begin n_fail++; $display("FAIL abort_restart_gnt0: got %b exp 0", gnt0); end
        n_tests++; if (rdata !== 4'h0) begin n_fail++; $display("FAIL abort_bank3_after: got %h exp 0", rdata); end
        req1 = 1'b0;
        tick();
        raddr = 2'd2; #1;
        n_tests++; if (rdata !== 4'h9) begin n_fail++; $display("FAIL abort_bank2: got %h exp 9", rdata); end
    endtask

    task automatic test_same_addr();
        do_reset();
        raddr = 2'd1;
        req0 = 1'b1; addr0 = 2'd1; data0 = 4'h5;
        req1 = 1'b1; addr1 = 2'd1; data1 = 4'h6;
        tick();
        n_tests++; if (gnt0 !== 1'b1) begin n_fail++; $display("FAIL same_gnt0: got %b exp 1", gnt0); end
        n_tests++; if (rdata !== 4'h0) begin n_fail++; $display("FAIL same_old0: got %h exp 0", rdata); end
        req0 = 1'b0;
        tick();
        n_tests++; if (rdata !== 4'h5) begin n_fail++; $display("FAIL same_first: got %h exp 5", rdata); end
        tick();
        n_tests++; if (gnt1 !== 1'b1) begin n_fail++; $display("FAIL same_gnt1: got %b exp 1", gnt1); end
        n_tests++; if (rdata !== 4'h5) begin n_fail++; $display("FAIL same_old5: got %h exp 5", rdata); end
        req1 = 1'b0;
        tick();
        n_tests++; if (gnt1 !== 1'b0) begin n_fail++; $display("FAIL same_gnt1_fall: got %b exp 0", gnt1); end
        n_tests++; if (rdata !== 4'h6) begin n_fail++; $display("FAIL same_final: got %h exp 6", rdata); end
    endtask

`ifdef ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        n_tests++; if (wr_cnt !== 8'd0) begin n_fail++; $display("FAIL stats_init: got %0d exp 0", wr_cnt); end
        req0 = 1'b1; addr0 = 2'd0; data0 = 4'h1;
        repeat (20) tick();
        n_tests++; if (wr_cnt !== 8'd10) begin n_fail++; $display("FAIL stats_10: got %0d exp 10", wr_cnt); end
        repeat (580) tick();
        n_tests++; if (wr_cnt !== 8'd255) begin n_fail++; $display("FAIL stats_sat: got %0d exp 255", wr_cnt); end
        req0 = 1'b0;
        rst = 1'b0;
        #1;
        n_tests++; if (wr_cnt !== 8'd0) begin n_fail++; $display("FAIL stats_reset: got %0d exp 0", wr_cnt); end
        rst = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_ptr();
        test_reset_abort();
        test_same_addr();
`ifdef ARB_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
